video_timing_gen: RTL and testbench

- Raster timing generator for the 640x480@60 HDMI path, clocked by the 25 MHz pixel clock.
- Produces current and look-ahead pixel coordinates, sync strobes, visible-area flags, frame/line pulses and a frame counter.
- Sits directly upstream of video_gen. video_gen registers its colour one cycle ahead using next_pixel_x/next_pixel_y/next_video_on.

---
 rtl/video_timing_gen_pkg.sv | 33 +++
 rtl/video_timing_gen_wrap.sv | 39 +++
 rtl/video_timing_gen.sv | 140 ++++++++++++++
 tb/tb_video_timing_gen.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/video_timing_gen_pkg.sv
// Shared raster timing constants and position types for the 640x480@60 video path.
package video_timing_gen_pkg;

  localparam int unsigned COORD_W     = 10;

  localparam int unsigned H_VISIBLE   = 640;
  localparam int unsigned H_FRONT     = 16;
  localparam int unsigned H_SYNC      = 96;
  localparam int unsigned H_BACK      = 48;

  localparam int unsigned V_VISIBLE   = 480;
  localparam int unsigned V_FRONT     = 10;
  localparam int unsigned V_SYNC      = 2;
  localparam int unsigned V_BACK      = 33;

  localparam logic        SYNC_ACTIVE = 1'b0;

  localparam int unsigned H_TOTAL     = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL     = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } pixel_pos_t;

  // Half-open window test [lo, hi) used for the sync pulse placement.
  function automatic logic in_window(input logic [COORD_W-1:0] v,
                                     input logic [COORD_W-1:0] lo,
                                     input logic [COORD_W-1:0] hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/video_timing_gen_wrap.sv
// Modulo-(MAX+1) counter. Clear parks the count on MAX so the following
// advance lands on 0; the advance value is exposed combinationally.
module wrap_counter #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned MAX   = 799
) (
  input  logic             clk,
  input  logic             en,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic [WIDTH-1:0] next_count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] ONE_V = WIDTH'(1);

  logic [WIDTH-1:0] count_r;

  // Advance value and terminal-count flag, independent of en.
  always_comb begin
    wrap       = (count_r == MAX_V);
    next_count = wrap ? {WIDTH{1'b0}} : (count_r + ONE_V);
  end

  // Count register: clear has priority, otherwise advance when enabled.
  always_ff @(posedge clk) begin
    if (clear) begin
      count_r <= MAX_V;
    end else if (en) begin
      count_r <= next_count;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing generator: current/look-ahead coordinates, sync strobes,
// visible-area flags, line/frame pulses and a frame counter.
module video_timing_gen #(
  parameter int unsigned H_VISIBLE   = video_timing_gen_pkg::H_VISIBLE,
  parameter int unsigned H_FRONT     = video_timing_gen_pkg::H_FRONT,
  parameter int unsigned H_SYNC      = video_timing_gen_pkg::H_SYNC,
  parameter int unsigned H_BACK      = video_timing_gen_pkg::H_BACK,
  parameter int unsigned V_VISIBLE   = video_timing_gen_pkg::V_VISIBLE,
  parameter int unsigned V_FRONT     = video_timing_gen_pkg::V_FRONT,
  parameter int unsigned V_SYNC      = video_timing_gen_pkg::V_SYNC,
  parameter int unsigned V_BACK      = video_timing_gen_pkg::V_BACK,
  parameter logic        SYNC_ACTIVE = video_timing_gen_pkg::SYNC_ACTIVE
) (
  input  logic       pixel_clk,
  input  logic       reset_n,
  input  logic       pix_en,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic [9:0] next_pixel_x,
  output logic [9:0] next_pixel_y,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       next_video_on,
  output logic       line_start,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  import video_timing_gen_pkg::*;

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // The coordinate counters are 10 bits wide.
  if ((H_TOTAL > 1024) || (V_TOTAL > 1024)) begin : g_bad_totals
    $error("video_timing_gen: H_TOTAL/V_TOTAL exceed 10-bit counter range");
  end

  localparam logic [9:0] H_VIS_V     = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS_V     = 10'(V_VISIBLE);
  localparam logic [9:0] HS_START_V  = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_END_V    = 10'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [9:0] VS_START_V  = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_END_V    = 10'(V_VISIBLE + V_FRONT + V_SYNC);

  logic       clear_s;
  logic       v_en_s;
  logic       h_wrap_s;
  logic       v_wrap_s;
  logic [9:0] x_s;
  logic [9:0] y_s;
  logic [9:0] x_inc_s;
  logic [9:0] y_inc_s;
  pixel_pos_t next_pos_s;
  logic       next_vis_s;
  logic       next_hsync_s;
  logic       next_vsync_s;
  logic       next_line_s;
  logic       next_frame_s;

  logic       hsync_r;
  logic       vsync_r;
  logic       video_on_r;
  logic       line_start_r;
  logic       frame_start_r;
  logic [7:0] frame_count_r;

  assign clear_s = ~reset_n;
  assign v_en_s  = pix_en & h_wrap_s;

  wrap_counter #(.WIDTH(10), .MAX(H_TOTAL - 1)) u_h_counter (
    .clk        (pixel_clk),
    .en         (pix_en),
    .clear      (clear_s),
    .count      (x_s),
    .next_count (x_inc_s),
    .wrap       (h_wrap_s)
  );

  wrap_counter #(.WIDTH(10), .MAX(V_TOTAL - 1)) u_v_counter (
    .clk        (pixel_clk),
    .en         (v_en_s),
    .clear      (clear_s),
    .count      (y_s),
    .next_count (y_inc_s),
    .wrap       (v_wrap_s)
  );

  // Position after the next enabled edge and the flags it implies; reset
  // parks the counters on the last pixel, so this reads (0,0) during reset.
  always_comb begin
    next_pos_s.x = x_inc_s;
    next_pos_s.y = h_wrap_s ? y_inc_s : y_s;
    next_vis_s   = (next_pos_s.x < H_VIS_V) && (next_pos_s.y < V_VIS_V);
    next_hsync_s = in_window(next_pos_s.x, HS_START_V, HS_END_V) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    next_vsync_s = in_window(next_pos_s.y, VS_START_V, VS_END_V) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    next_line_s  = (next_pos_s.x == 10'd0);
    next_frame_s = next_line_s && (next_pos_s.y == 10'd0);
  end

  // Flags registered from the next position so they line up with the counters.
  always_ff @(posedge pixel_clk) begin
    if (!reset_n) begin
      hsync_r       <= ~SYNC_ACTIVE;
      vsync_r       <= ~SYNC_ACTIVE;
      video_on_r    <= 1'b0;
      line_start_r  <= 1'b0;
      frame_start_r <= 1'b0;
      frame_count_r <= 8'hFF;
    end else if (pix_en) begin
      hsync_r       <= next_hsync_s;
      vsync_r       <= next_vsync_s;
      video_on_r    <= next_vis_s;
      line_start_r  <= next_line_s;
      frame_start_r <= next_frame_s;
      frame_count_r <= next_frame_s ? (frame_count_r + 8'd1) : frame_count_r;
    end else begin
      hsync_r       <= hsync_r;
      vsync_r       <= vsync_r;
      video_on_r    <= video_on_r;
      line_start_r  <= line_start_r;
      frame_start_r <= frame_start_r;
      frame_count_r <= frame_count_r;
    end
  end

  assign pixel_x       = x_s;
  assign pixel_y       = y_s;
  assign next_pixel_x  = next_pos_s.x;
  assign next_pixel_y  = next_pos_s.y;
  assign next_video_on = next_vis_s;
  assign hsync         = hsync_r;
  assign vsync         = vsync_r;
  assign video_on      = video_on_r;
  assign line_start    = line_start_r;
  assign frame_start   = frame_start_r;
  assign frame_count   = frame_count_r;

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen using a scaled-down raster
// (15x12 totals) so that hundreds of frames fit in a short run.
module tb_video_timing_gen;

  localparam int HV = 8;
  localparam int HF = 2;
  localparam int HS = 3;
  localparam int HB = 2;
  localparam int VV = 6;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 2;
  localparam int HT = HV + HF + HS + HB;  // 15
  localparam int VT = VV + VF + VS + VB;  // 12

  logic       pixel_clk = 1'b0;
  logic       reset_n   = 1'b0;
  logic       pix_en    = 1'b0;
  logic [9:0] pixel_x, pixel_y, next_pixel_x, next_pixel_y;
  logic       hsync, vsync, video_on, next_video_on, line_start, frame_start;
  logic [7:0] frame_count;

  video_timing_gen #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_ACTIVE(1'b0)
  ) dut (
    .pixel_clk     (pixel_clk),
    .reset_n       (reset_n),
    .pix_en        (pix_en),
    .pixel_x       (pixel_x),
    .pixel_y       (pixel_y),
    .next_pixel_x  (next_pixel_x),
    .next_pixel_y  (next_pixel_y),
    .hsync         (hsync),
    .vsync         (vsync),
    .video_on      (video_on),
    .next_video_on (next_video_on),
    .line_start    (line_start),
    .frame_start   (frame_start),
    .frame_count   (frame_count)
  );

  always #5 pixel_clk = ~pixel_clk;

  typedef struct {
    int x; int y; int nx; int ny; int fc;
    bit hs; bit vs; bit von; bit nvon; bit ls; bit fs;
  } exp_t;

  exp_t q[$];

  int m_x, m_y, m_fc;
  bit m_hs, m_vs, m_von, m_ls, m_fs;

  int vectors     = 0;
  int miscompares = 0;
  int prints      = 0;

  task automatic report(input string name, input logic [31:0] act, input logic [31:0] exp);
    if (prints < 30) $display("FAIL %s: got %0d expected %0d", name, act, exp);
    prints++;
  endtask

  task automatic fld(input string name, input logic [31:0] act, input logic [31:0] exp, inout bit bad);
    if (act !== exp) begin
      bad = 1'b1;
      report(name, act, exp);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      report(name, act, exp);
    end
  endtask

  // Apply one cycle of stimulus, advance the reference model, queue its prediction.
  task automatic step(input bit r, input bit e);
    exp_t ev;
    @(negedge pixel_clk);
    reset_n = r;
    pix_en  = e;
    @(posedge pixel_clk);
    if (!r) begin
      m_x = HT - 1; m_y = VT - 1; m_fc = 255;
      m_hs = 1'b1; m_vs = 1'b1; m_von = 1'b0; m_ls = 1'b0; m_fs = 1'b0;
    end else if (e) begin
      if (m_x == HT - 1) begin
        m_x = 0;
        m_y = (m_y == VT - 1) ? 0 : m_y + 1;
      end else begin
        m_x = m_x + 1;
      end
      m_hs  = !((m_x >= HV + HF) && (m_x < HV + HF + HS));
      m_vs  = !((m_y >= VV + VF) && (m_y < VV + VF + VS));
      m_von = (m_x < HV) && (m_y < VV);
      m_ls  = (m_x == 0);
      m_fs  = (m_x == 0) && (m_y == 0);
      if (m_fs) m_fc = (m_fc + 1) % 256;
    end
    ev.x = m_x; ev.y = m_y; ev.fc = m_fc;
    ev.hs = m_hs; ev.vs = m_vs; ev.von = m_von; ev.ls = m_ls; ev.fs = m_fs;
    ev.nx = (m_x == HT - 1) ? 0 : m_x + 1;
    ev.ny = (m_x == HT - 1) ? ((m_y == VT - 1) ? 0 : m_y + 1) : m_y;
    ev.nvon = (ev.nx < HV) && (ev.ny < VV);
    q.push_back(ev);
  endtask

  // Monitor: pop one prediction per clock and compare every output against it.
  initial begin
    exp_t ev;
    bit bad;
    forever begin
      @(posedge pixel_clk);
      #1;
      if (q.size() > 0) begin
        ev = q.pop_front();
        bad = 1'b0;
        fld("pixel_x",       32'(pixel_x),       32'(ev.x),    bad);
        fld("pixel_y",       32'(pixel_y),       32'(ev.y),    bad);
        fld("next_pixel_x",  32'(next_pixel_x),  32'(ev.nx),   bad);
        fld("next_pixel_y",  32'(next_pixel_y),  32'(ev.ny),   bad);
        fld("hsync",         32'(hsync),         32'(ev.hs),   bad);
        fld("vsync",         32'(vsync),         32'(ev.vs),   bad);
        fld("video_on",      32'(video_on),      32'(ev.von),  bad);
        fld("next_video_on", 32'(next_video_on), 32'(ev.nvon), bad);
        fld("line_start",    32'(line_start),    32'(ev.ls),   bad);
        fld("frame_start",   32'(frame_start),   32'(ev.fs),   bad);
        fld("frame_count",   32'(frame_count),   32'(ev.fc),   bad);
        vectors++;
        if (bad) miscompares++;
      end
    end
  end

  // Watchdog so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Directed stimulus sequence.
  initial begin
    int n;
    int fs_seen;
    int hs_low;
    int hold_x;

    // Reset for 5 cycles with pix_en high.
    repeat (5) step(1'b0, 1'b1);
    #2;
    chk("reset_x",  32'(pixel_x),     32'd14);
    chk("reset_y",  32'(pixel_y),     32'd11);
    chk("reset_fc", 32'(frame_count), 32'hFF);
    chk("reset_nx", 32'(next_pixel_x), 32'd0);

    // First edge after release enters (0,0) and starts frame 0.
    step(1'b1, 1'b1);
    #2;
    chk("first_x",  32'(pixel_x),     32'd0);
    chk("first_y",  32'(pixel_y),     32'd0);
    chk("first_fs", 32'(frame_start), 32'd1);
    chk("first_ls", 32'(line_start),  32'd1);
    chk("first_fc", 32'(frame_count), 32'd0);

    // Run 256 more frames; the 257th frame start wraps the counter to 0.
    fs_seen = 0;
    for (int i = 0; i < 256 * HT * VT; i++) begin
      step(1'b1, 1'b1);
      #2;
      if (frame_start === 1'b1) fs_seen++;
    end
    chk("frame_starts",   32'(fs_seen),     32'd256);
    chk("wrap_fc",        32'(frame_count), 32'd0);
    chk("wrap_fs",        32'(frame_start), 32'd1);

    // Advance to the pixel just before the hsync window, then stall 7 cycles.
    n = 0;
    while ((m_x != HV + HF - 1) && (n < 2 * HT)) begin
      step(1'b1, 1'b1);
      n++;
    end
    #2;
    chk("stall_pos", 32'(pixel_x), 32'd9);
    hold_x = 32'(pixel_x);
    repeat (7) step(1'b1, 1'b0);
    #2;
    chk("stall_hold_x", 32'(pixel_x), 32'(hold_x));
    chk("stall_hsync",  32'(hsync),   32'd1);

    // Resume: sync pulse must begin at x=10 and last exactly HS enabled cycles.
    step(1'b1, 1'b1);
    #2;
    chk("resume_x",     32'(pixel_x), 32'd10);
    chk("resume_hsync", 32'(hsync),   32'd0);
    hs_low = 1;
    for (int i = 0; i < HT - 1; i++) begin
      step(1'b1, 1'b1);
      #2;
      if (hsync === 1'b0) hs_low++;
    end
    chk("hsync_width", 32'(hs_low), 32'd3);

    // Irregular enable pattern across line and frame boundaries.
    for (int i = 0; i < 600; i++) step(1'b1, (i % 3) != 0);

    // Mid-frame reset at (5,3) with pix_en low.
    n = 0;
    while (!((m_x == 5) && (m_y == 3)) && (n < 2 * HT * VT)) begin
      step(1'b1, 1'b1);
      n++;
    end
    #2;
    chk("midrst_pos_y", 32'(pixel_y), 32'd3);
    step(1'b0, 1'b0);
    #2;
    chk("midrst_x",  32'(pixel_x),     32'd14);
    chk("midrst_y",  32'(pixel_y),     32'd11);
    chk("midrst_fc", 32'(frame_count), 32'hFF);
    chk("midrst_hs", 32'(hsync),       32'd1);
    step(1'b1, 1'b1);
    #2;
    chk("restart_x",  32'(pixel_x),     32'd0);
    chk("restart_y",  32'(pixel_y),     32'd0);
    chk("restart_fc", 32'(frame_count), 32'd0);
    chk("restart_fs", 32'(frame_start), 32'd1);
    repeat (2 * HT) step(1'b1, 1'b1);

    repeat (2) @(posedge pixel_clk);
    #2;
    chk("queue_drained", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
